// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester/controller bundle for the SDRAM port arbiter
interface sdram_arbiter_if;
  // Frame reader
  logic        i_Rd_Request;
  logic [1:0]  i_Rd_Command;
  logic [21:0] i_Rd_Address;
  logic        o_Rd_Grant;
  // Pixel writer
  logic        i_Wr_Request;
  logic [1:0]  i_Wr_Command;
  logic [21:0] i_Wr_Address;
  logic        o_Wr_Grant;
  // Controller side
  logic        i_Refresh_Done;
  logic [1:0]  o_Command;
  logic [21:0] o_Address;
  logic        o_Refresh_Overrun;

  // Arbiter view
  modport slave (
    input  i_Rd_Request, i_Rd_Command, i_Rd_Address,
    input  i_Wr_Request, i_Wr_Command, i_Wr_Address,
    input  i_Refresh_Done,
    output o_Rd_Grant, o_Wr_Grant, o_Command, o_Address, o_Refresh_Overrun
  );

  // Requester/controller view
  modport master (
    output i_Rd_Request, i_Rd_Command, i_Rd_Address,
    output i_Wr_Request, i_Wr_Command, i_Wr_Address,
    output i_Refresh_Done,
    input  o_Rd_Grant, o_Wr_Grant, o_Command, o_Address, o_Refresh_Overrun
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin RD/WR owner arbitration with periodic auto-refresh
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int MAX_HOLD         = 64
) (
  input logic           i_Clk,
  input logic           i_Reset,
  sdram_arbiter_if.slave bus
);

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_REFRESH = 2'd3;

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] REFRESH_RELOAD = CW'(REFRESH_INTERVAL - 1);
  localparam logic [HW-1:0] HOLD_LIMIT     = HW'(MAX_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_RD,
    GRANT_WR,
    RELEASE,
    REFRESH
  } state_t;

  state_t        state_q;
  logic [CW-1:0] refresh_cnt_q;
  logic [CW-1:0] refresh_cnt_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          pending_q;
  logic          overrun_q;
  logic          last_wr_q;   // 1: WR was the most recent owner
  logic          owner_wr_q;  // 1: WR owns the port (GRANT/RELEASE)
  logic          rd_grant_q;
  logic          wr_grant_q;
  logic [1:0]    cmd_q;
  logic [21:0]   addr_q;

  logic          refresh_due;
  logic [1:0]    owner_cmd;
  logic [21:0]   owner_addr;
  logic          owner_req;
  logic          other_req;
  logic          owner_idle;
  logic          revoke;
  logic          rd_wins;

  // Timer/hold next values and owner-relative views of the request lines
  always_comb begin
    refresh_due   = (refresh_cnt_q == '0);
    refresh_cnt_d = refresh_due ? REFRESH_RELOAD : refresh_cnt_q - 1'b1;
    hold_d        = (hold_q >= HOLD_LIMIT) ? HOLD_LIMIT : hold_q + 1'b1;
    owner_cmd     = owner_wr_q ? bus.i_Wr_Command : bus.i_Rd_Command;
    owner_addr    = owner_wr_q ? bus.i_Wr_Address : bus.i_Rd_Address;
    owner_req     = owner_wr_q ? bus.i_Wr_Request : bus.i_Rd_Request;
    other_req     = owner_wr_q ? bus.i_Rd_Request : bus.i_Wr_Request;
    owner_idle    = (owner_cmd == CMD_IDLE);
    // Only ever revoke at a command boundary
    revoke        = owner_idle &&
                    (!owner_req || pending_q || ((hold_q >= HOLD_LIMIT) && other_req));
    // Ties go to whoever did not own the port last
    rd_wins       = bus.i_Rd_Request && (!bus.i_Wr_Request || last_wr_q);
  end

  // Arbitration FSM, refresh timer and registered controller-side outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= IDLE;
      refresh_cnt_q <= REFRESH_RELOAD;
      hold_q        <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      last_wr_q     <= 1'b1;
      owner_wr_q    <= 1'b0;
      rd_grant_q    <= 1'b0;
      wr_grant_q    <= 1'b0;
      cmd_q         <= CMD_IDLE;
      addr_q        <= '0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      if (refresh_due) begin
        pending_q <= 1'b1;
        if (pending_q) overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          rd_grant_q <= 1'b0;
          wr_grant_q <= 1'b0;
          cmd_q      <= CMD_IDLE;
          addr_q     <= '0;
          if (pending_q) begin
            state_q   <= REFRESH;
            cmd_q     <= CMD_REFRESH;
            // A timeout landing on the entry edge re-arms the next refresh
            pending_q <= refresh_due;
          end else if (rd_wins) begin
            state_q    <= GRANT_RD;
            owner_wr_q <= 1'b0;
            rd_grant_q <= 1'b1;
            hold_q     <= '0;
          end else if (bus.i_Wr_Request) begin
            state_q    <= GRANT_WR;
            owner_wr_q <= 1'b1;
            wr_grant_q <= 1'b1;
            hold_q     <= '0;
          end
        end
        GRANT_RD, GRANT_WR: begin
          cmd_q  <= owner_cmd;
          addr_q <= owner_addr;
          hold_q <= hold_d;
          if (revoke) begin
            state_q    <= RELEASE;
            rd_grant_q <= 1'b0;
            wr_grant_q <= 1'b0;
          end
        end
        RELEASE: begin
          // Drain a command the owner launched as its grant fell
          cmd_q  <= owner_cmd;
          addr_q <= owner_addr;
          if (owner_idle) begin
            state_q   <= IDLE;
            last_wr_q <= owner_wr_q;
          end
        end
        REFRESH: begin
          cmd_q  <= CMD_REFRESH;
          addr_q <= '0;
          if (bus.i_Refresh_Done) begin
            state_q <= IDLE;
            cmd_q   <= CMD_IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          rd_grant_q <= 1'b0;
          wr_grant_q <= 1'b0;
          cmd_q      <= CMD_IDLE;
          addr_q     <= '0;
        end
      endcase
    end
  end

  assign bus.o_Rd_Grant        = rd_grant_q;
  assign bus.o_Wr_Grant        = wr_grant_q;
  assign bus.o_Command         = cmd_q;
  assign bus.o_Address         = addr_q;
  assign bus.o_Refresh_Overrun = overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;
  localparam logic [1:0] CMD_REFRESH = 2'd3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sdram_arbiter_if bus();

  sdram_arbiter #(.REFRESH_INTERVAL(390), .MAX_HOLD(64)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_Rd_Request = 1'b0; bus.i_Rd_Command = CMD_IDLE; bus.i_Rd_Address = '0;
    bus.i_Wr_Request = 1'b0; bus.i_Wr_Command = CMD_IDLE; bus.i_Wr_Address = '0;
    bus.i_Refresh_Done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset state
    do_reset();
    chk("reset_rd_grant", 32'(bus.o_Rd_Grant), 0);
    chk("reset_wr_grant", 32'(bus.o_Wr_Grant), 0);
    chk("reset_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    chk("reset_addr", 32'(bus.o_Address), 0);
    chk("reset_overrun", 32'(bus.o_Refresh_Overrun), 0);

    // 1. RD alone: 8 READs, then idle and drop request
    bus.i_Rd_Request = 1'b1;
    tick();
    chk("t1_grant", 32'(bus.o_Rd_Grant), 1);
    chk("t1_grant_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    for (int i = 0; i < 8; i++) begin
      bus.i_Rd_Command = CMD_READ;
      bus.i_Rd_Address = 22'h100 + 22'(i);
      tick();
      chk("t1_cmd", 32'(bus.o_Command), 32'(CMD_READ));
      chk("t1_addr", 32'(bus.o_Address), 32'h100 + 32'(i));
      chk("t1_wr_grant", 32'(bus.o_Wr_Grant), 0);
    end
    bus.i_Rd_Command = CMD_IDLE;
    bus.i_Rd_Request = 1'b0;
    tick();
    chk("t1_release_grant", 32'(bus.o_Rd_Grant), 0);
    chk("t1_release_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    tick();
    chk("t1_idle_rd", 32'(bus.o_Rd_Grant), 0);
    chk("t1_idle_wr", 32'(bus.o_Wr_Grant), 0);

    // 2. Simultaneous requests: RD first, then WR
    do_reset();
    bus.i_Rd_Request = 1'b1;
    bus.i_Wr_Request = 1'b1;
    tick();
    chk("t2_rd_first", 32'(bus.o_Rd_Grant), 1);
    chk("t2_wr_waits", 32'(bus.o_Wr_Grant), 0);
    bus.i_Rd_Command = CMD_READ;
    bus.i_Rd_Address = 22'h2AAAA;
    bus.i_Wr_Command = CMD_WRITE;  // non-owner command must not leak through
    bus.i_Wr_Address = 22'h15555;
    tick();
    chk("t2_rd_cmd", 32'(bus.o_Command), 32'(CMD_READ));
    chk("t2_rd_addr", 32'(bus.o_Address), 32'h2AAAA);
    bus.i_Rd_Command = CMD_IDLE;
    bus.i_Wr_Command = CMD_IDLE;
    bus.i_Rd_Request = 1'b0;
    tick();
    chk("t2_release_rd", 32'(bus.o_Rd_Grant), 0);
    chk("t2_release_wr", 32'(bus.o_Wr_Grant), 0);
    tick();
    chk("t2_idle_wr", 32'(bus.o_Wr_Grant), 0);
    tick();
    chk("t2_wr_granted", 32'(bus.o_Wr_Grant), 1);
    chk("t2_rd_not", 32'(bus.o_Rd_Grant), 0);
    bus.i_Wr_Command = CMD_WRITE;
    bus.i_Wr_Address = 22'h3FFFFF;
    bus.i_Rd_Command = CMD_READ;
    bus.i_Rd_Address = 22'h000123;
    tick();
    chk("t2_wr_cmd", 32'(bus.o_Command), 32'(CMD_WRITE));
    chk("t2_wr_addr", 32'(bus.o_Address), 32'h3FFFFF);

    // 3. Hold limit: RD keeps requesting with idle gaps while WR waits
    do_reset();
    bus.i_Rd_Request = 1'b1;
    tick();
    chk("t3_rd_grant", 32'(bus.o_Rd_Grant), 1);
    bus.i_Wr_Request = 1'b1;
    for (int j = 0; j < 63; j++) begin
      bus.i_Rd_Command = ((j % 2) == 1 || j == 62) ? CMD_IDLE : CMD_READ;
      tick();
      chk("t3_still_held", 32'(bus.o_Rd_Grant), 1);
    end
    bus.i_Rd_Command = CMD_IDLE;  // hold counter now at 63
    tick();
    chk("t3_revoked", 32'(bus.o_Rd_Grant), 0);
    chk("t3_no_wr_yet", 32'(bus.o_Wr_Grant), 0);
    tick();
    chk("t3_idle", 32'(bus.o_Wr_Grant), 0);
    tick();
    chk("t3_wr_granted", 32'(bus.o_Wr_Grant), 1);
    chk("t3_rd_off", 32'(bus.o_Rd_Grant), 0);

    // 4. Refresh comes due (edge 390) during an RD burst spanning edges 385..396
    do_reset();
    bus.i_Rd_Request = 1'b1;
    tick();
    chk("t4_grant", 32'(bus.o_Rd_Grant), 1);
    for (int e = 2; e <= 384; e++) tick();
    chk("t4_held_idle", 32'(bus.o_Rd_Grant), 1);
    for (int e = 385; e <= 396; e++) begin
      bus.i_Rd_Command = CMD_READ;
      bus.i_Rd_Address = 22'(e);
      tick();
      chk("t4_burst_cmd", 32'(bus.o_Command), 32'(CMD_READ));
      chk("t4_burst_grant", 32'(bus.o_Rd_Grant), 1);
    end
    bus.i_Rd_Command = CMD_IDLE;
    tick();
    chk("t4_release", 32'(bus.o_Rd_Grant), 0);
    chk("t4_release_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    tick();
    chk("t4_idle_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    tick();
    chk("t4_refresh_cmd", 32'(bus.o_Command), 32'(CMD_REFRESH));
    chk("t4_refresh_addr", 32'(bus.o_Address), 0);
    tick();
    tick();
    chk("t4_refresh_hold", 32'(bus.o_Command), 32'(CMD_REFRESH));
    chk("t4_refresh_nogrant", 32'(bus.o_Rd_Grant), 0);
    bus.i_Refresh_Done = 1'b1;
    tick();
    bus.i_Refresh_Done = 1'b0;
    chk("t4_done_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    tick();
    chk("t4_regrant", 32'(bus.o_Rd_Grant), 1);
    chk("t4_overrun", 32'(bus.o_Refresh_Overrun), 0);

    // 5. Owner issues READ on the edge its grant falls
    do_reset();
    bus.i_Rd_Request = 1'b1;
    tick();
    chk("t5_grant", 32'(bus.o_Rd_Grant), 1);
    bus.i_Rd_Request = 1'b0;
    tick();
    chk("t5_revoked", 32'(bus.o_Rd_Grant), 0);
    bus.i_Rd_Command = CMD_READ;
    bus.i_Rd_Address = 22'h0ABCDE;
    bus.i_Wr_Request = 1'b1;
    tick();
    chk("t5_drain_cmd", 32'(bus.o_Command), 32'(CMD_READ));
    chk("t5_drain_addr", 32'(bus.o_Address), 32'h0ABCDE);
    chk("t5_no_wr", 32'(bus.o_Wr_Grant), 0);
    tick();
    chk("t5_drain_cmd2", 32'(bus.o_Command), 32'(CMD_READ));
    chk("t5_no_wr2", 32'(bus.o_Wr_Grant), 0);
    bus.i_Rd_Command = CMD_IDLE;
    tick();
    chk("t5_idle_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));
    chk("t5_idle_wr", 32'(bus.o_Wr_Grant), 0);
    tick();
    chk("t5_wr_granted", 32'(bus.o_Wr_Grant), 1);

    // 6. Refresh never acknowledged -> sticky overrun
    do_reset();
    for (int e = 1; e <= 390; e++) tick();
    chk("t6_pre_refresh", 32'(bus.o_Command), 32'(CMD_IDLE));
    tick();  // edge 391
    chk("t6_refresh", 32'(bus.o_Command), 32'(CMD_REFRESH));
    for (int e = 392; e <= 1169; e++) tick();
    chk("t6_no_overrun_yet", 32'(bus.o_Refresh_Overrun), 0);
    tick();  // edge 1170
    chk("t6_overrun", 32'(bus.o_Refresh_Overrun), 1);
    bus.i_Refresh_Done = 1'b1;
    tick();
    bus.i_Refresh_Done = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    chk("t6_sticky", 32'(bus.o_Refresh_Overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_reset_clears", 32'(bus.o_Refresh_Overrun), 0);
    chk("t6_reset_cmd", 32'(bus.o_Command), 32'(CMD_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
